// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - state encoding and SPselect levels shared by the shift sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Level driven onto the dcell SPselect line
    localparam logic SP_LOAD  = 1'b1;   // parallel load from D
    localparam logic SP_SHIFT = 1'b0;   // serial shift from S

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - shift-step prescaler with clear and hold
// Ports:
//   clk   in  board clock
//   rst   in  asynchronous active-low reset
//   clear in  forces the count to 0 (wins over hold)
//   hold  in  freezes the count and suppresses tick
//   tick  out combinational, high in the cycle the count sits at DIV_MAX
module tick_gen #(
    parameter int DIV_MAX = 50_000_000 - 1,
    parameter int DIV_W   = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV_MAX);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            if (cnt_q == TERM) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - load/rotate sequencer for the 16-cell dcell chain
// Ports:
//   clk       in  board clock
//   rst       in  asynchronous active-low reset
//   start     in  async button level; a rising edge starts a sequence
//   abort     in  clk-domain level cancel
//   shifts    in  rotate step count, sampled on the start edge
//   pause     in  freezes SHIFT (port exists only with SEQ_PAUSE_EN defined)
//   reg_ce    out one-cycle enable to every register cell
//   sp_sel    out SPselect: 1 = parallel load, 0 = serial shift
//   busy      out high while a sequence is running
//   done      out one-cycle pulse at sequence end
//   shift_cnt out rotate steps issued in the current/last sequence
// Macro: SEQ_PAUSE_EN adds the pause port.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DIV_MAX = 50_000_000 - 1,
    parameter int DIV_W   = 26,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] shifts,
`ifdef SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic             reg_ce,
    output logic             sp_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt
);

    seq_state_t       state_q, state_d;
    logic             start_meta_q, start_meta_d;
    logic             start_sync_q, start_sync_d;
    logic             start_prev_q, start_prev_d;
    logic [CNT_W-1:0] shifts_q, shifts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reg_ce_q, reg_ce_d;
    logic             sp_sel_q, sp_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             start_rise;
    logic             hold;
    logic             tick;
    logic [CNT_W-1:0] cnt_inc;

`ifdef SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Counter only runs in SHIFT, so hold is irrelevant in other states.
    tick_gen #(
        .DIV_MAX (DIV_MAX),
        .DIV_W   (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear ((state_q != ST_SHIFT) || abort),
        .hold  (hold),
        .tick  (tick)
    );

    assign start_rise = start_sync_q & ~start_prev_q;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    always_comb begin
        start_meta_d = start;
        start_sync_d = start_meta_q;
        start_prev_d = start_sync_q;
        state_d      = state_q;
        shifts_d     = shifts_q;
        cnt_d        = cnt_q;
        reg_ce_d     = 1'b0;
        sp_sel_d     = SP_SHIFT;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        // Abort outranks everything; in IDLE it also swallows a coincident start edge.
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        shifts_d = shifts;
                        cnt_d    = '0;
                        state_d  = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    reg_ce_d = 1'b1;
                    sp_sel_d = SP_LOAD;
                    busy_d   = 1'b1;
                    state_d  = (shifts_q == '0) ? ST_DONE : ST_SHIFT;
                end
                ST_SHIFT: begin
                    busy_d = 1'b1;
                    if (tick) begin
                        reg_ce_d = 1'b1;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == shifts_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            shifts_q     <= '0;
            cnt_q        <= '0;
            reg_ce_q     <= 1'b0;
            sp_sel_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_meta_q <= start_meta_d;
            start_sync_q <= start_sync_d;
            start_prev_q <= start_prev_d;
            shifts_q     <= shifts_d;
            cnt_q        <= cnt_d;
            reg_ce_q     <= reg_ce_d;
            sp_sel_q     <= sp_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign reg_ce    = reg_ce_q;
    assign sp_sel    = sp_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign shift_cnt = cnt_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer (DIV_MAX=3, CNT_W=5)
module tb_shift_sequencer;

    localparam int CNT_W = 5;
    localparam int STEP  = 4;   // DIV_MAX+1

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pause = 1'b0;
    logic [CNT_W-1:0] shifts = '0;
    logic             reg_ce, sp_sel, busy, done;
    logic [CNT_W-1:0] shift_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer #(
        .DIV_MAX (3),
        .DIV_W   (2),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .shifts    (shifts),
`ifdef SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .reg_ce    (reg_ce),
        .sp_sel    (sp_sel),
        .busy      (busy),
        .done      (done),
        .shift_cnt (shift_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a sequence accepted at edge t0 loads at t0+1, then issues a step
    // after every STEP unpaused clock edges, and signals done one edge after the last step.
    int   cyc = 0;
    logic s1 = 0, s2 = 0, s3 = 0;
    bit   on = 0;
    int   t0 = 0, done_at = -1, act = 0, seq_len = 0;
    logic e_rc = 0, e_sp = 0, e_busy = 0, e_done = 0;
    int   e_cnt = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            s1 = 0; s2 = 0; s3 = 0; on = 0; done_at = -1;
            e_rc = 0; e_sp = 0; e_busy = 0; e_done = 0; e_cnt = 0;
        end else begin
            cyc++;
            e_rc = 0; e_sp = 0; e_busy = 0; e_done = 0;
            if (on) begin
                if (abort) begin
                    on = 0;
                end else if (cyc == t0 + 1) begin
                    e_rc = 1; e_sp = 1; e_busy = 1;
                    if (seq_len == 0) done_at = cyc + 1;
                end else if (cyc == done_at) begin
                    e_done = 1; e_busy = 1; on = 0;
                end else begin
                    e_busy = 1;
                    if (!pause) begin
                        act++;
                        if (act == STEP) begin
                            act = 0; e_rc = 1; e_cnt++;
                            if (e_cnt == seq_len) done_at = cyc + 1;
                        end
                    end
                end
            end else if (s2 && !s3 && !abort) begin
                on = 1; t0 = cyc; seq_len = int'(shifts); act = 0; e_cnt = 0; done_at = -1;
            end
            s3 = s2; s2 = s1; s1 = start;
        end
    end

    // dcell chain: load {0,sw} on SPselect=1, rotate left on SPselect=0
    logic [15:0] led = 16'h0;
    logic [7:0]  sw  = 8'hA5;
    initial forever begin
        @(posedge clk);
        if (reg_ce === 1'b1) led = (sp_sel === 1'b1) ? {8'h00, sw} : {led[14:0], led[15]};
    end

    int rc_log[$];
    int done_log[$];
    int sp_hi = 0;

    initial forever begin
        @(negedge clk);
        chk("reg_ce", {31'd0, reg_ce}, {31'd0, e_rc});
        chk("sp_sel", {31'd0, sp_sel}, {31'd0, e_sp});
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("done", {31'd0, done}, {31'd0, e_done});
        chk("shift_cnt", 32'(shift_cnt), 32'(e_cnt));
        if (reg_ce === 1'b1) rc_log.push_back(cyc);
        if (reg_ce === 1'b1 && sp_sel === 1'b1) sp_hi++;
        if (done === 1'b1) done_log.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        rc_log.delete();
        done_log.delete();
        sp_hi = 0;
    endtask

    task automatic begin_seq(input int s, output int n);
        clear_logs();
        shifts = CNT_W'(s);
        start  = 1'b1;
        n      = cyc + 1;
        step(1);
        start  = 1'b0;
    endtask

    task automatic wait_rc(input int k, input string name);
        int i = 0;
        while (rc_log.size() < k && i < 300) begin
            step(1);
            i++;
        end
        chk(name, 32'(rc_log.size() >= k), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int i = 0;
        while (done_log.size() == 0 && i < 300) begin
            step(1);
            i++;
        end
        chk(name, 32'(done_log.size()), 32'd1);
    endtask

    task automatic chk_offsets(input string name, input int n, input int exp_q[$]);
        chk({name, "_npulse"}, 32'(rc_log.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < rc_log.size()) chk($sformatf("%s_p%0d", name, i), 32'(rc_log[i] - n), 32'(exp_q[i]));
        end
    endtask

    function automatic int done_off(input int n);
        return (done_log.size() > 0) ? done_log[0] - n : -1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int q[$];

        // reset state
        step(2);
        chk("rst_reg_ce", {31'd0, reg_ce}, 32'd0);
        chk("rst_sp_sel", {31'd0, sp_sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cnt", 32'(shift_cnt), 32'd0);
        rst = 1'b1;
        step(3);

        // four rotate steps
        begin_seq(4, n);
        wait_done("t2_wait_done");
        step(1);
        q = '{3, 7, 11, 15, 19};
        chk_offsets("t2", n, q);
        chk("t2_done_off", 32'(done_off(n)), 32'd20);
        chk("t2_sp_hi", 32'(sp_hi), 32'd1);
        chk("t2_cnt", 32'(shift_cnt), 32'd4);
        chk("t2_led", 32'(led), 32'h0A50);
        step(5);

        // zero steps
        begin_seq(0, n);
        wait_done("t3_wait_done");
        step(3);
        q = '{3};
        chk_offsets("t3", n, q);
        chk("t3_done_off", 32'(done_off(n)), 32'd4);
        chk("t3_cnt", 32'(shift_cnt), 32'd0);
        step(3);

        // abort after the second step
        begin_seq(6, n);
        wait_rc(3, "t4_wait_rc");
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t4_busy", {31'd0, busy}, 32'd0);
        step(40);
        chk("t4_rc", 32'(rc_log.size()), 32'd3);
        chk("t4_done", 32'(done_log.size()), 32'd0);
        chk("t4_cnt", 32'(shift_cnt), 32'd2);

        // re-pulsed start while busy
        begin_seq(3, n);
        step(5);
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        start = 1'b1; step(1); start = 1'b0;
        step(30);
        chk("t5a_done", 32'(done_log.size()), 32'd1);
        chk("t5a_rc", 32'(rc_log.size()), 32'd4);

        // start held high
        clear_logs();
        shifts = CNT_W'(3);
        start  = 1'b1;
        step(100);
        start  = 1'b0;
        step(30);
        chk("t5b_done", 32'(done_log.size()), 32'd1);
        chk("t5b_rc", 32'(rc_log.size()), 32'd4);

        // reset mid-SHIFT
        begin_seq(5, n);
        wait_rc(2, "t1_wait_rc");
        step(2);
        rst = 1'b0;
        #1;
        chk("t1_reg_ce", {31'd0, reg_ce}, 32'd0);
        chk("t1_sp_sel", {31'd0, sp_sel}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_done", {31'd0, done}, 32'd0);
        chk("t1_cnt", 32'(shift_cnt), 32'd0);
        step(2);
        rst = 1'b1;
        clear_logs();
        step(30);
        chk("t1_no_rc", 32'(rc_log.size()), 32'd0);

`ifdef SEQ_PAUSE_EN
        // pause after first step
        begin_seq(4, n);
        wait_rc(2, "t6_wait_rc");
        pause = 1'b1;
        k = rc_log.size();
        step(10);
        chk("t6_paused_rc", 32'(rc_log.size()), 32'(k));
        pause = 1'b0;
        wait_done("t6_wait_done");
        step(1);
        q = '{3, 7, 21, 25, 29};
        chk_offsets("t6", n, q);
        chk("t6_done_off", 32'(done_off(n)), 32'd30);
        chk("t6_cnt", 32'(shift_cnt), 32'd4);
        step(3);

        // abort while paused
        begin_seq(4, n);
        wait_rc(2, "t6b_wait_rc");
        pause = 1'b1;
        step(3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        pause = 1'b0;
        chk("t6b_busy", {31'd0, busy}, 32'd0);
        step(30);
        chk("t6b_rc", 32'(rc_log.size()), 32'd2);
        chk("t6b_done", 32'(done_log.size()), 32'd0);
        chk("t6b_cnt", 32'(shift_cnt), 32'd1);
`endif

        // randomized traffic against the reference
        clear_logs();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) start = ~start;
            abort  = ($urandom_range(0, 49) == 0);
`ifdef SEQ_PAUSE_EN
            pause  = ($urandom_range(0, 5) == 0);
`endif
            shifts = CNT_W'($urandom_range(0, 7));
            step(1);
        end
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        step(60);
        chk("rand_some_done", 32'(done_log.size() > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
